// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: constants, FSM
// state encoding and the queue entry layout.
package fetch_queue_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries with flush; the head entry
// is presented combinationally.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fq_entry_t                wdata,
    output fq_entry_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    fq_entry_t     mem_r [DEPTH];

    // Pointers and occupancy; flush discards everything and beats push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; stale contents are never visible because empty masks them
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = (count_r == CW'(0));
    assign full  = (count_r == CW'(DEPTH));
    assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, runs a single-outstanding
// req/ack fetch to instruction memory and feeds buffered words to ID.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    output logic        InstValid
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t     state_r;
    fq_state_t     state_next_s;
    logic [31:0]   pc_r;
    logic [31:0]   pc_next_s;
    logic [31:0]   req_addr_r;
    logic [31:0]   req_addr_next_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          room_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_next_s;
    fq_entry_t     head_s;
    fq_entry_t     push_entry_s;

    // A redirect cancels both the consume and any arriving word this cycle
    assign pop_s        = !empty_s && !Stall && !Redirect;
    assign push_s       = (state_r == REQ) && ImemAck && !Redirect && !full_s;
    assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);
    assign room_s       = (count_next_s < CW'(DEPTH));
    assign push_entry_s = '{pc: req_addr_r, inst: ImemData};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (Redirect),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Fetch FSM next state, fetch PC and request address
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        req_addr_next_s = req_addr_r;
        case (state_r)
            IDLE: begin
                if (Redirect) begin
                    pc_next_s = RedirectPC;
                end else if (room_s) begin
                    req_addr_next_s = pc_r;
                    state_next_s    = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (Redirect) begin
                    pc_next_s    = RedirectPC;
                    // Without the ack the response is still owed and must be swallowed
                    state_next_s = ImemAck ? IDLE : DROP;
                end else if (ImemAck) begin
                    pc_next_s = req_addr_r + PC_INC;
                    if (room_s) begin
                        req_addr_next_s = req_addr_r + PC_INC;
                        state_next_s    = REQ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            DROP: begin
                if (Redirect) begin
                    pc_next_s = RedirectPC;
                end else begin
                    pc_next_s = pc_r;
                end
                state_next_s = ImemAck ? IDLE : DROP;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, fetch PC and request address registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            req_addr_r <= req_addr_next_s;
        end
    end

    assign ImemReq   = (state_r == REQ) || (state_r == DROP);
    assign ImemAddr  = req_addr_r;
    assign InstValid = !empty_s;
    assign Inst      = empty_s ? NOP : head_s.inst;
    assign InstPC    = empty_s ? NOP : head_s.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: programmable-latency memory responder, queue-level
// reference model with per-cycle compare, and directed scenarios.
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] XOR_K  = 32'hA5A5_A5A5;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Stall;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        InstValid;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) u_dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemData   (ImemData),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Stall      (Stall),
        .Inst       (Inst),
        .InstPC     (InstPC),
        .InstValid  (InstValid)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after 'lat' wait cycles, data = addr ^ XOR_K
    int lat = 0;
    int wait_cnt = 0;
    bit mem_busy = 1'b0;
    initial begin
        ImemAck  = 1'b0;
        ImemData = 32'h0;
        forever begin
            @(negedge Clk);
            if (!Reset_n || !ImemReq) begin
                ImemAck  = 1'b0;
                ImemData = 32'hDEAD_BEEF;
                wait_cnt = 0;
                mem_busy = 1'b0;
            end else if (wait_cnt >= lat) begin
                ImemAck  = 1'b1;
                ImemData = ImemAddr ^ XOR_K;
                wait_cnt = 0;
                mem_busy = 1'b0;
            end else begin
                ImemAck  = 1'b0;
                ImemData = 32'hDEAD_BEEF;
                wait_cnt++;
                mem_busy = 1'b1;
            end
        end
    end

    // Reference model: the instruction stream ID should see
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] fetch_pc = RST_PC;
    logic [31:0] drop_addr = 32'h0;
    bit          drop = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            mq.delete();
            fetch_pc = RST_PC;
            drop     = 1'b0;
            chk_en   = 1'b1;
        end else if (Redirect) begin
            mq.delete();
            if (ImemAck) begin
                drop = 1'b0;
            end else if (mem_busy && !drop) begin
                drop      = 1'b1;
                drop_addr = fetch_pc;
            end
            fetch_pc = RedirectPC;
        end else begin
            if (mq.size() > 0 && !Stall) begin
                void'(mq.pop_front());
            end
            if (ImemAck) begin
                if (drop) begin
                    drop = 1'b0;
                end else begin
                    mq.push_back('{fetch_pc, fetch_pc ^ XOR_K});
                    fetch_pc = fetch_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_valid", {31'd0, InstValid}, {31'd0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                chk("m_pc", InstPC, mq[0].pc);
                chk("m_inst", Inst, mq[0].inst);
            end else begin
                chk("m_pc_empty", InstPC, 32'h0);
                chk("m_inst_empty", Inst, 32'h0);
            end
            if (ImemReq) begin
                chk("m_addr", ImemAddr, drop ? drop_addr : fetch_pc);
            end
            if (mq.size() == DEPTH) begin
                chk("m_req_full", {31'd0, ImemReq}, 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        step(3);
        chk("rst_req", {31'd0, ImemReq}, 32'd0);
        chk("rst_valid", {31'd0, InstValid}, 32'd0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_pc", InstPC, 32'h0);

        // Zero-wait streaming from the wrapping reset PC
        Reset_n = 1'b1;
        step(1);
        chk("n0_req", {31'd0, ImemReq}, 32'd1);
        chk("n0_addr", ImemAddr, 32'hFFFF_FFF8);
        chk("n0_valid", {31'd0, InstValid}, 32'd0);
        step(1);
        chk("n1_valid", {31'd0, InstValid}, 32'd1);
        chk("n1_pc", InstPC, 32'hFFFF_FFF8);
        chk("n1_inst", Inst, 32'h5A5A_5A5D);
        chk("n1_addr", ImemAddr, 32'hFFFF_FFFC);
        step(1);
        chk("n2_pc", InstPC, 32'hFFFF_FFFC);
        step(1);
        chk("n3_pc", InstPC, 32'h0000_0000);
        chk("n3_inst", Inst, 32'hA5A5_A5A5);
        step(1);
        chk("n4_pc", InstPC, 32'h0000_0004);

        // Redirect to 0 with Stall held: fill to DEPTH, then drain
        Redirect = 1'b1; RedirectPC = 32'h0; Stall = 1'b1;
        step(1);
        Redirect = 1'b0;
        chk("r1_valid", {31'd0, InstValid}, 32'd0);
        chk("r1_req", {31'd0, ImemReq}, 32'd0);
        step(4);
        chk("r5_addr", ImemAddr, 32'h0000_000C);
        step(1);
        chk("full_req", {31'd0, ImemReq}, 32'd0);
        chk("full_pc", InstPC, 32'h0000_0000);
        step(1);
        chk("full_req2", {31'd0, ImemReq}, 32'd0);
        Stall = 1'b0;
        step(1);
        chk("drain_pc4", InstPC, 32'h0000_0004);
        chk("resume_req", {31'd0, ImemReq}, 32'd1);
        chk("resume_addr", ImemAddr, 32'h0000_0010);
        step(2);
        chk("drain_pc12", InstPC, 32'h0000_000C);
        step(1);
        chk("stream_pc16", InstPC, 32'h0000_0010);

        // Redirect while a latency-3 request is pending: response is dropped
        lat = 3;
        step(2);
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        step(1);
        Redirect = 1'b0;
        chk("drop_valid", {31'd0, InstValid}, 32'd0);
        chk("drop_req", {31'd0, ImemReq}, 32'd1);
        step(2);
        chk("post_drop_idle", {31'd0, ImemReq}, 32'd0);
        step(1);
        chk("redir_addr", ImemAddr, 32'h0000_0100);
        chk("redir_req", {31'd0, ImemReq}, 32'd1);
        step(4);
        chk("redir_valid", {31'd0, InstValid}, 32'd1);
        chk("redir_pc", InstPC, 32'h0000_0100);
        chk("redir_inst", Inst, 32'hA5A5_A4A5);

        // Redirect coinciding with the ack of 0x20 while two entries wait
        lat = 0; Stall = 1'b1;
        step(8);
        chk("full2_req", {31'd0, ImemReq}, 32'd0);
        Redirect = 1'b1; RedirectPC = 32'h0000_0018;
        step(1);
        Redirect = 1'b0;
        step(3);
        chk("ack20_addr", ImemAddr, 32'h0000_0020);
        chk("ack20_head", InstPC, 32'h0000_0018);
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step(1);
        Redirect = 1'b0;
        chk("ackredir_valid", {31'd0, InstValid}, 32'd0);
        chk("ackredir_req", {31'd0, ImemReq}, 32'd0);
        step(1);
        chk("ackredir_addr", ImemAddr, 32'h0000_0200);
        Stall = 1'b0;
        step(1);
        chk("ackredir_pc", InstPC, 32'h0000_0200);

        // Reset in the middle of a pending request
        lat = 3;
        step(1);
        chk("pre_rst_req", {31'd0, ImemReq}, 32'd1);
        Reset_n = 1'b0;
        step(1);
        chk("mid_rst_req", {31'd0, ImemReq}, 32'd0);
        chk("mid_rst_valid", {31'd0, InstValid}, 32'd0);
        step(1);
        Reset_n = 1'b1; lat = 0;
        step(1);
        chk("rerst_addr", ImemAddr, 32'hFFFF_FFF8);
        step(1);
        chk("rerst_pc", InstPC, 32'hFFFF_FFF8);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue between instruction memory and the ID stage.
- Owns the fetch PC and issues one word request at a time to instruction memory over a req/ack handshake.
- Buffers up to DEPTH returned words with their PCs and presents the oldest to ID.
- Honours ID's Stall; flushes on taken Branch/Jump redirects, including discarding a response already in flight.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- ImemReq  out  1  request valid; held high until ImemAck.
- ImemAddr  out  32  word address of the pending request; stable while ImemReq is high.
- ImemAck  in  1  response strobe; ImemData is valid in this cycle; may arrive in the same cycle ImemReq rises.
- ImemData  in  32  instruction word.
- Redirect  in  1  taken Branch or Jump from ID; one-cycle pulse.
- RedirectPC  in  32  new fetch address, sampled when Redirect=1.
- Stall  in  1  ID cannot accept; the head entry is not consumed.
- Inst  out  32  head instruction; 0 when the queue is empty.
- InstPC  out  32  PC of the head instruction; 0 when the queue is empty.
- InstValid  out  1  queue not empty.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - FSM goes to IDLE; count=0; rd/wr pointers=0.
  - PC=RESET_PC; ReqAddr=RESET_PC.
  - ImemReq=0, InstValid=0, Inst=0, InstPC=0.
  - Instruction memory shares Reset_n, so no response survives reset.
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}, circular; pointers wrap modulo DEPTH; count runs 0..DEPTH.
- Outputs: Inst, InstPC and InstValid are driven combinationally from the head entry.
- Pop: occurs when InstValid=1, Stall=0 and Redirect=0.
- FSM states IDLE, REQ, DROP:
  - IDLE: ImemReq=0. If Redirect=0 and count_next<DEPTH, load ReqAddr<=PC and go to REQ.
  - REQ: ImemReq=1, ImemAddr=ReqAddr.
    - Ack with no Redirect: push {ReqAddr, ImemData}; PC<=ReqAddr+4. If count_next<DEPTH, set ReqAddr<=ReqAddr+4 and stay in REQ; otherwise go to IDLE.
    - Ack with Redirect in the same cycle: discard the data; go to IDLE.
    - No ack with Redirect: go to DROP.
  - DROP: ImemReq=1 with ImemAddr=ReqAddr (stale) until ack; the ack data is discarded; then go to IDLE.
- count_next = count + push − pop.
- Since at most one request is outstanding and it is issued only when count_next<DEPTH, a push never overflows.
- Redirect, in any state:
  - All entries are flushed: count<=0, rd=wr.
  - PC<=RedirectPC.
  - Redirect overrides a same-cycle pop and push.
  - A redirect while in DROP only updates PC.
- Throughput:
  - A zero-wait memory (ack in the request cycle) gives 1 instruction/cycle.
  - First InstValid after reset or redirect arrives 1 cycle after the first ack; ID sees the first instruction 2 cycles after reset release.
- Full with Stall=1: the FSM sits in IDLE with ImemReq=0 and no pointer changes.
- Full with a simultaneous pop: no push happens in that cycle because none is pending; the request reissues next cycle.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0. No alignment check.
- Reset asserted mid-request: ImemReq drops to 0 the next cycle; the response is not awaited.

Decomposition:
- Shared pipeline package holds:
  - NOP constant 32'h00000000;
  - PC increment constant 4;
  - FSM state encoding (IDLE=0, REQ=1, DROP=2);
  - the entry struct {pc, inst}.
- Sub-module fetch_fifo is natural: parameterised DEPTH, with push/pop/flush inputs and full/empty/count outputs.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset release, zero-wait memory, ImemData=addr^32'hA5A5A5A5, Stall=0 → ImemAddr sequence 0,4,8,…; InstPC 0,4,8,… one per cycle, each with the matching Inst; InstValid first high 2 cycles after release.
- Stall=1 held → after 4 acks count=4 and ImemReq=0; release Stall → 4 pops in 4 cycles with InstPC 0,4,8,12, fetch resumes at 16.
- Redirect to 32'h100 while in REQ with memory latency 3, ack arriving 2 cycles later → that ack's data never appears; next ImemAddr=32'h100; first InstPC after the redirect is 32'h100.
- Redirect to 32'h200 in the same cycle as an ack of PC 32'h20 with 2 entries queued → InstValid=0 next cycle; 32'h20 never seen; next request is 32'h200.
- RESET_PC=32'hFFFFFFF8 → InstPC sequence FFFFFFF8, FFFFFFFC, 00000000; Reset_n=0 mid-REQ → ImemReq=0 and InstValid=0 one cycle later.
